// File: rtl/ysyx_23060061_lsu_fsm.sv
// Load/store unit: accepts one instruction from EXU, issues at most one
// memory transaction, aligns/extends load data, and hands the result plus
// write-back side-band to the WBU. Non-memory ops pass through in one cycle.
module ysyx_23060061_lsu_fsm (
   input  logic        clk,
   input  logic        rst,
   input  logic        exu_valid,
   output logic        lsu_ready,
   input  logic [1:0]  MemRW,
   input  logic [2:0]  memExt,
   input  logic [31:0] memAddr,
   input  logic [31:0] memDataW,
   input  logic [3:0]  wmask,
   input  logic [1:0]  WBSel,
   input  logic [31:0] aluOut,
   input  logic [31:0] snpc,
   input  logic [4:0]  rd,
   input  logic        RegWrite,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata,
   input  logic        mem_resp_err,
   output logic        lsu_valid,
   input  logic        wbu_ready,
   output logic [31:0] memDataR,
   output logic        lsu_err,
   output logic [1:0]  WBSel_o,
   output logic [31:0] aluOut_o,
   output logic [31:0] snpc_o,
   output logic [4:0]  rd_o,
   output logic        RegWrite_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   state_e      state_q, state_d;
   logic [1:0]  memrw_q;
   logic [2:0]  ext_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wmask_q;
   logic [1:0]  wbsel_q;
   logic [31:0] aluout_q;
   logic [31:0] snpc_q;
   logic [4:0]  rd_q;
   logic        regwrite_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        is_load, is_store, in_is_mem;
   logic [31:0] rshift;
   logic [31:0] load_d;

   assign is_load   = (memrw_q == 2'b01);
   assign is_store  = (memrw_q == 2'b10);
   assign in_is_mem = (MemRW == 2'b01) || (MemRW == 2'b10);

   // Next-state logic; responses only count while in WAIT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (exu_valid)      state_d = in_is_mem ? REQ : DONE;
         REQ:     if (mem_req_ready)  state_d = WAIT;
         WAIT:    if (mem_resp_valid) state_d = DONE;
         DONE:    if (wbu_ready)      state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Load alignment: bytes shifted past bit 31 become zero before extension.
   always_comb begin
      rshift = mem_resp_rdata >> {addr_q[1:0], 3'b000};
      case (ext_q)
         3'b000:  load_d = {{24{rshift[7]}}, rshift[7:0]};
         3'b001:  load_d = {{16{rshift[15]}}, rshift[15:0]};
         3'b100:  load_d = {24'h0, rshift[7:0]};
         3'b101:  load_d = {16'h0, rshift[15:0]};
         default: load_d = rshift;
      endcase
   end

   // Latch the instruction on accept; capture the response in WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         memrw_q    <= '0;
         ext_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         wbsel_q    <= '0;
         aluout_q   <= '0;
         snpc_q     <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else if (state_q == IDLE && exu_valid) begin
         memrw_q    <= MemRW;
         ext_q      <= memExt;
         addr_q     <= memAddr;
         wdata_q    <= memDataW;
         wmask_q    <= wmask;
         wbsel_q    <= WBSel;
         aluout_q   <= aluOut;
         snpc_q     <= snpc;
         rd_q       <= rd;
         regwrite_q <= RegWrite;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else if (state_q == WAIT && mem_resp_valid) begin
         rdata_q    <= is_load ? load_d : 32'h0;
         err_q      <= mem_resp_err;
      end
   end

   // Ready depends on state (and reset) only, never on exu_valid.
   assign lsu_ready     = (state_q == IDLE) && !rst;
   assign mem_req_valid = (state_q == REQ);
   assign mem_req_we    = (state_q == REQ) && is_store;
   assign mem_req_addr  = {addr_q[31:2], 2'b00};
   assign mem_req_wdata = wdata_q << {addr_q[1:0], 3'b000};
   assign mem_req_wmask = (state_q == REQ && is_store) ? (wmask_q << addr_q[1:0]) : 4'b0000;

   assign lsu_valid  = (state_q == DONE);
   assign memDataR   = rdata_q;
   assign lsu_err    = err_q;
   assign WBSel_o    = wbsel_q;
   assign aluOut_o   = aluout_q;
   assign snpc_o     = snpc_q;
   assign rd_o       = rd_q;
   assign RegWrite_o = regwrite_q;

endmodule

// File: tb/tb_ysyx_23060061_lsu_fsm.sv
// Randomized bench for the LSU: drives EXU, memory and WBU sides cycle by
// cycle on the falling edge and compares against a byte-level model.
module tb_ysyx_23060061_lsu_fsm;

   logic        clk, rst, exu_valid, lsu_ready;
   logic [1:0]  MemRW;
   logic [2:0]  memExt;
   logic [31:0] memAddr, memDataW;
   logic [3:0]  wmask;
   logic [1:0]  WBSel;
   logic [31:0] aluOut, snpc;
   logic [4:0]  rd;
   logic        RegWrite;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid, mem_resp_err;
   logic [31:0] mem_resp_rdata;
   logic        lsu_valid, wbu_ready, lsu_err;
   logic [31:0] memDataR;
   logic [1:0]  WBSel_o;
   logic [31:0] aluOut_o, snpc_o;
   logic [4:0]  rd_o;
   logic        RegWrite_o;

   int n_pass = 0;
   int n_total = 0;

   ysyx_23060061_lsu_fsm dut (
      .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
      .MemRW(MemRW), .memExt(memExt), .memAddr(memAddr), .memDataW(memDataW),
      .wmask(wmask), .WBSel(WBSel), .aluOut(aluOut), .snpc(snpc), .rd(rd),
      .RegWrite(RegWrite), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid),
      .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
      .lsu_valid(lsu_valid), .wbu_ready(wbu_ready), .memDataR(memDataR),
      .lsu_err(lsu_err), .WBSel_o(WBSel_o), .aluOut_o(aluOut_o),
      .snpc_o(snpc_o), .rd_o(rd_o), .RegWrite_o(RegWrite_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Load result from byte lanes: lanes past byte 3 read as zero.
   function automatic logic [31:0] model_load(input logic [2:0] ext,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
      logic [7:0] b [0:7];
      int o, lo, hi, v;
      for (int i = 0; i < 8; i++) b[i] = (i < 4) ? word[8*i +: 8] : 8'h00;
      o  = int'(off);
      lo = int'(b[o]);
      hi = int'(b[o+1]);
      case (ext)
         3'd0: begin v = lo; if (v >= 128) v = v - 256; end
         3'd4: v = lo;
         3'd1: begin v = hi * 256 + lo; if (v >= 32768) v = v - 65536; end
         3'd5: v = hi * 256 + lo;
         default: return {b[o+3], b[o+2], b[o+1], b[o]};
      endcase
      return 32'(v);
   endfunction

   // Store data placed into byte lanes starting at the byte offset.
   function automatic logic [31:0] model_wdata(input logic [1:0] off, input logic [31:0] wd);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         if (int'(off) + i < 4) r[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [3:0] model_wmask(input logic [1:0] off, input logic [3:0] wm);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         if (int'(off) + i < 4) r[int'(off)+i] = wm[i];
      return r;
   endfunction

   // One instruction end to end with given memory/WBU stall lengths.
   task automatic run_op(input logic [1:0] rw, input logic [2:0] ext,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] wm, input logic [1:0] wbs,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [4:0] rdn, input logic rwen,
                         input logic [31:0] rdata, input logic err,
                         input int req_dly, input int resp_dly, input int wb_dly,
                         input bit stray, input string tag);
      int n;
      bit is_mem;
      logic [31:0] exp_wd, exp_data;
      logic [3:0]  exp_wm;
      logic        exp_err;
      is_mem = (rw == 2'b01) || (rw == 2'b10);
      n = 0;
      while (lsu_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n_total++;
      if (lsu_ready !== 1'b1) $display("FAIL %s ready_wait: lsu_ready=%b exp 1", tag, lsu_ready);
      else n_pass++;
      exu_valid = 1'b1; MemRW = rw; memExt = ext; memAddr = addr; memDataW = wd;
      wmask = wm; WBSel = wbs; aluOut = alu; snpc = pc; rd = rdn; RegWrite = rwen;
      @(negedge clk);
      exu_valid = 1'b0; MemRW = 2'($urandom); memExt = 3'($urandom); memAddr = $urandom;
      memDataW = $urandom; wmask = 4'($urandom); WBSel = 2'($urandom); aluOut = $urandom;
      snpc = $urandom; rd = 5'($urandom); RegWrite = 1'($urandom);
      exp_wd = model_wdata(addr[1:0], wd);
      exp_wm = (rw == 2'b10) ? model_wmask(addr[1:0], wm) : 4'b0000;
      if (is_mem) begin
         for (int k = 0; k <= req_dly; k++) begin
            n_total++;
            if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask, lsu_valid, lsu_ready}
                !== {1'b1, (rw == 2'b10), {addr[31:2], 2'b00}, exp_wd, exp_wm, 1'b0, 1'b0})
               $display("FAIL %s req[%0d]: got v=%b we=%b a=%h d=%h m=%b lv=%b rdy=%b exp v=1 we=%b a=%h d=%h m=%b lv=0 rdy=0",
                        tag, k, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
                        lsu_valid, lsu_ready, (rw == 2'b10), {addr[31:2], 2'b00}, exp_wd, exp_wm);
            else n_pass++;
            mem_req_ready  = (k == req_dly);
            mem_resp_valid = stray && ($urandom_range(0, 1) == 1);
            mem_resp_rdata = $urandom;
            mem_resp_err   = 1'($urandom);
            @(negedge clk);
         end
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
         for (int k = 0; k <= resp_dly; k++) begin
            n_total++;
            if ({mem_req_valid, lsu_valid, lsu_ready} !== 3'b000)
               $display("FAIL %s wait[%0d]: got req_v=%b lsu_v=%b rdy=%b exp 000", tag, k,
                        mem_req_valid, lsu_valid, lsu_ready);
            else n_pass++;
            mem_resp_valid = (k == resp_dly);
            mem_resp_rdata = (k == resp_dly) ? rdata : $urandom;
            mem_resp_err   = (k == resp_dly) ? err : 1'($urandom);
            @(negedge clk);
         end
         mem_resp_valid = 1'b0;
      end
      exp_data = (rw == 2'b01) ? model_load(ext, addr[1:0], rdata) : 32'h0;
      exp_err  = is_mem ? err : 1'b0;
      for (int j = 0; j <= wb_dly; j++) begin
         n_total++;
         if ({lsu_valid, lsu_ready, mem_req_valid, memDataR, lsu_err, WBSel_o, aluOut_o, snpc_o, rd_o, RegWrite_o}
             !== {1'b1, 1'b0, 1'b0, exp_data, exp_err, wbs, alu, pc, rdn, rwen})
            $display("FAIL %s done[%0d]: got lv=%b rdy=%b rq=%b d=%h e=%b wb=%0d alu=%h pc=%h rd=%0d rw=%b exp lv=1 rdy=0 rq=0 d=%h e=%b wb=%0d alu=%h pc=%h rd=%0d rw=%b",
                     tag, j, lsu_valid, lsu_ready, mem_req_valid, memDataR, lsu_err, WBSel_o, aluOut_o,
                     snpc_o, rd_o, RegWrite_o, exp_data, exp_err, wbs, alu, pc, rdn, rwen);
         else n_pass++;
         wbu_ready      = (j == wb_dly);
         mem_resp_valid = stray && ($urandom_range(0, 1) == 1);
         mem_resp_rdata = $urandom;
         mem_resp_err   = 1'($urandom);
         @(negedge clk);
      end
      wbu_ready = 1'b0; mem_resp_valid = 1'b0;
      n_total++;
      if ({lsu_valid, lsu_ready} !== 2'b01)
         $display("FAIL %s release: got lv=%b rdy=%b exp lv=0 rdy=1", tag, lsu_valid, lsu_ready);
      else n_pass++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      n_total++;
      if ({lsu_ready, lsu_valid, mem_req_valid, mem_req_we, mem_req_wmask, memDataR, lsu_err,
           WBSel_o, aluOut_o, snpc_o, rd_o, RegWrite_o} !== '0)
         $display("FAIL reset_state: got rdy=%b lv=%b rq=%b we=%b m=%b d=%h e=%b alu=%h pc=%h rd=%0d rw=%b exp all 0",
                  lsu_ready, lsu_valid, mem_req_valid, mem_req_we, mem_req_wmask, memDataR, lsu_err,
                  aluOut_o, snpc_o, rd_o, RegWrite_o);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({lsu_ready, lsu_valid} !== 2'b10)
         $display("FAIL reset_release: got rdy=%b lv=%b exp rdy=1 lv=0", lsu_ready, lsu_valid);
      else n_pass++;
   endtask

   task automatic test_alu;
      run_op(2'b00, 3'd2, 32'h0, 32'h0, 4'h0, 2'd1, 32'h1234, 32'h8000_0004, 5'd5, 1'b1,
             32'h0, 1'b0, 0, 0, 0, 1'b0, "alu");
      run_op(2'b11, 3'd2, 32'h8000_0000, 32'h0, 4'hF, 2'd2, 32'hAAAA_5555, 32'h8000_0008, 5'd9, 1'b0,
             32'h0, 1'b0, 0, 0, 0, 1'b0, "memrw11");
   endtask

   task automatic test_load_ext;
      run_op(2'b01, 3'd0, 32'h8000_0003, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 5'd1, 1'b1,
             32'h80FF_0000, 1'b0, 0, 0, 0, 1'b0, "lb");
      run_op(2'b01, 3'd4, 32'h8000_0003, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 5'd1, 1'b1,
             32'h80FF_0000, 1'b0, 0, 0, 0, 1'b0, "lbu");
      run_op(2'b01, 3'd1, 32'h8000_0003, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 5'd2, 1'b1,
             32'hF0FF_0000, 1'b0, 0, 0, 0, 1'b0, "lh_misaligned");
      run_op(2'b01, 3'd1, 32'h8000_0002, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 5'd2, 1'b1,
             32'h9234_5678, 1'b0, 0, 0, 0, 1'b0, "lh");
   endtask

   task automatic test_store;
      run_op(2'b10, 3'd1, 32'h8000_0002, 32'h0000_BEEF, 4'b0011, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0,
             32'hDEAD_BEEF, 1'b0, 0, 0, 0, 1'b0, "sh");
      run_op(2'b10, 3'd2, 32'h8000_0003, 32'h1122_3344, 4'b1111, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0,
             32'h0, 1'b0, 0, 0, 0, 1'b0, "sw_misaligned");
   endtask

   task automatic test_stall;
      run_op(2'b10, 3'd2, 32'h8000_0101, 32'h0000_00A5, 4'b0001, 2'd0, 32'h55, 32'h66, 5'd3, 1'b0,
             32'h0, 1'b0, 3, 1, 2, 1'b1, "stall");
   endtask

   task automatic test_err;
      run_op(2'b01, 3'd2, 32'h8000_0040, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 5'd7, 1'b1,
             32'hCAFE_F00D, 1'b1, 0, 0, 0, 1'b0, "lw_err");
      run_op(2'b01, 3'd2, 32'h8000_0044, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 5'd8, 1'b1,
             32'h1357_9BDF, 1'b0, 0, 0, 0, 1'b0, "lw_after_err");
   endtask

   task automatic test_reset_mid;
      exu_valid = 1'b1; MemRW = 2'b01; memExt = 3'd2; memAddr = 32'h8000_0010;
      aluOut = 32'h77; snpc = 32'h88; rd = 5'd4; RegWrite = 1'b1; WBSel = 2'd1;
      @(negedge clk);
      exu_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if ({lsu_ready, lsu_valid, mem_req_valid, mem_req_we, mem_req_wmask, memDataR, lsu_err,
           WBSel_o, aluOut_o, snpc_o, rd_o, RegWrite_o, mem_req_addr} !== '0)
         $display("FAIL rst_in_wait: got rdy=%b lv=%b rq=%b d=%h e=%b alu=%h pc=%h rd=%0d a=%h exp all 0",
                  lsu_ready, lsu_valid, mem_req_valid, memDataR, lsu_err, aluOut_o, snpc_o, rd_o, mem_req_addr);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF; mem_resp_err = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
      n_total++;
      if ({lsu_ready, lsu_valid, mem_req_valid, memDataR, lsu_err} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0})
         $display("FAIL stray_resp: got rdy=%b lv=%b rq=%b d=%h e=%b exp rdy=1 lv=0 rq=0 d=0 e=0",
                  lsu_ready, lsu_valid, mem_req_valid, memDataR, lsu_err);
      else n_pass++;
      run_op(2'b01, 3'd2, 32'h8000_0010, 32'h0, 4'h0, 2'd1, 32'h77, 32'h88, 5'd4, 1'b1,
             32'h0BAD_CAFE, 1'b0, 1, 0, 0, 1'b0, "lw_after_rst");
   endtask

   task automatic test_random;
      int exts [8] = '{0, 1, 2, 4, 5, 3, 6, 7};
      int wms  [3] = '{1, 3, 15};
      for (int i = 0; i < 60; i++) begin
         run_op(2'($urandom), 3'(exts[$urandom_range(0, 7)]), $urandom, $urandom,
                4'(wms[$urandom_range(0, 2)]), 2'($urandom), $urandom, $urandom,
                5'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'b1, "random");
      end
   endtask

   initial begin
      rst = 1'b1; exu_valid = 1'b0; MemRW = '0; memExt = '0; memAddr = '0; memDataW = '0;
      wmask = '0; WBSel = '0; aluOut = '0; snpc = '0; rd = '0; RegWrite = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;
      wbu_ready = 1'b0;
      test_reset;
      test_alu;
      test_load_ext;
      test_store;
      test_stall;
      test_err;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ysyx_23060061_lsu_fsm.md
# ysyx_23060061_lsu_fsm

Load/store unit sitting directly downstream of the combined decode/execute stage and upstream of write-back. It accepts one instruction at a time over a valid/ready handshake, performs at most one memory transaction on a request/response data bus, aligns and extends load data, and presents the result with the write-back side-band to the WBU. Non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters; data and address widths are fixed at 32 bits.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- exu_valid  in  1  upstream instruction valid.
- lsu_ready  out  1  LSU can accept an instruction; high only in IDLE.
- MemRW  in  2  00 none, 01 load, 10 store, 11 treated as none.
- memExt  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes behave as LW.
- memAddr  in  32  byte address.
- memDataW  in  32  store data, LSB-justified.
- wmask  in  4  unshifted store byte mask: 0001, 0011 or 1111.
- WBSel, aluOut, snpc, rd, RegWrite  in  2/32/32/5/1  write-back side-band, latched on accept.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  32  word-aligned address, {memAddr[31:2],2'b00}.
- mem_req_wdata  out  32  memDataW << (8*memAddr[1:0]).
- mem_req_wmask  out  4  (wmask << memAddr[1:0]) truncated to 4 bits; 0000 on reads.
- mem_resp_valid  in  1  response pulse; one per accepted request.
- mem_resp_rdata  in  32  read word, meaningful only for reads.
- mem_resp_err  in  1  bus error, qualified by mem_resp_valid.
- lsu_valid  out  1  result valid to WBU.
- wbu_ready  in  1  WBU accepts the result.
- memDataR  out  32  aligned, extended load data; 0 for non-loads.
- lsu_err  out  1  bus error for this instruction, qualified by lsu_valid.
- WBSel_o, aluOut_o, snpc_o, rd_o, RegWrite_o  out  latched side-band.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset to IDLE.
- IDLE: lsu_ready=1. On exu_valid, latch all inputs.
  - If MemRW is 01 or 10, go to REQ.
  - Otherwise go to DONE with memDataR=0 and lsu_err=0.
- REQ: mem_req_valid=1 and the request fields are held stable. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, capture the data and error, then go to DONE.
  - For loads, the word is shifted right by 8*addr[1:0].
  - LB/LBU take byte 0 with sign/zero extension; LH/LHU take bytes 1:0 with sign/zero extension; LW passes through.
  - For stores, memDataR=0.
- DONE: lsu_valid=1. Outputs are held until wbu_ready, then go to IDLE.
- Misaligned access: no exception. Mask lanes shifted past byte 3 are dropped. Read bytes shifted past bit 31 read as zero before extension.
- A response arriving in IDLE, REQ or DONE is ignored.
- A request handshake and a response in the same cycle are not a completion: the response is sampled only in WAIT.
- RegWrite_o is passed through unchanged; lsu_err does not gate it.

## Timing
- Reset values: lsu_ready=0 during the rst cycle and 1 from the following cycle. mem_req_valid=0, mem_req_we=0, mem_req_wmask=0, lsu_valid=0, lsu_err=0, memDataR=0, and all latched outputs are 0.
- Non-memory instruction accepted at cycle T: lsu_valid at T+1. With wbu_ready=1 at T+1, lsu_ready returns at T+2.
- Memory instruction accepted at T:
  - mem_req_valid from T+1 until the handshake at cycle H.
  - Response at cycle R ≥ H+1.
  - lsu_valid at R+1.
  - Minimum latency is 3 cycles to lsu_valid, with 4-cycle throughput.
- mem_req_valid must not drop, and its fields must not change, before mem_req_ready.
- lsu_valid and its data are held stable while wbu_ready=0.
- rst asserted in any state: the next cycle is IDLE with all outputs at reset values. An in-flight request is abandoned, and a later stray response is ignored.
- lsu_ready is combinational from state only; it has no path from exu_valid.

## Test plan
- ALU op (MemRW=00, aluOut=0x1234, rd=5, RegWrite=1), wbu_ready=1 -> lsu_valid one cycle after accept, aluOut_o=0x1234, rd_o=5, memDataR=0, no mem_req_valid.
- LB at memAddr=0x80000003, mem_resp_rdata=0x80FF_0000 -> mem_req_addr=0x80000000, mem_req_wmask=0000, memDataR=0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH at memAddr=0x80000002, memDataW=0x0000BEEF, wmask=0011 -> mem_req_we=1, mem_req_wdata=0xBEEF0000, mem_req_wmask=1100, memDataR=0.
- mem_req_ready low for 3 cycles and response 2 cycles after the handshake, wbu_ready low for 2 cycles -> request fields stable throughout, lsu_valid held 3 cycles, lsu_ready only after the wbu_ready handshake.
- LW with mem_resp_err=1 -> lsu_valid with lsu_err=1. The next instruction has lsu_err=0.
- rst asserted in WAIT, then a stray mem_resp_valid in IDLE -> IDLE with reset outputs, no lsu_valid, and the next LW completes normally.
